// File: rtl/screen_scanner.sv
// Raster scan-out for the Hack screen buffer: walks (h,v), fetches one RAM word per 16 pixels
// and serialises it LSB-first, with sync/active/frame_start delayed to stay aligned with pixel.
module screen_scanner #(
   parameter int unsigned ADDR_WIDTH  = 14,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SCREEN_BASE = 0,
   parameter int unsigned H_ACTIVE    = 512,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 64,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_ACTIVE    = 256,
   parameter int unsigned V_FRONT     = 4,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 18
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ADDR_WIDTH-1:0] address_video,
   input  logic [DATA_WIDTH-1:0] data_video,
   output logic                  pixel,
   output logic                  active,
   output logic                  hsync_n,
   output logic                  vsync_n,
   output logic                  frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HW      = $clog2(H_TOTAL + 1);
   localparam int unsigned VW      = $clog2(V_TOTAL + 1);
   localparam int unsigned WPR     = H_ACTIVE / 16;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [HW-1:0]         r_h;
   logic [VW-1:0]         r_v;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_shift;
   // Stage 1 aligns with the RAM read, stage 2 with the shift-register output.
   logic                  r_vis1, r_hs1, r_vs1, r_fs1, r_load1;
   logic                  r_vis2, r_hs2, r_vs2, r_fs2;

   logic                  w_h_last, w_v_last;
   logic [HW-1:0]         w_h_nxt;
   logic [VW-1:0]         w_v_nxt;
   logic                  w_vis, w_hs, w_vs, w_fs, w_word_start;
   logic                  w_fetch;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;

   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);
   assign w_h_nxt  = w_h_last ? '0 : r_h + 1'b1;
   assign w_v_nxt  = !w_h_last ? r_v : (w_v_last ? '0 : r_v + 1'b1);

   assign w_vis        = (r_h < H_ACT) && (r_v < V_ACT);
   assign w_hs         = (r_h >= HS_BEGIN) && (r_h < HS_END);
   assign w_vs         = (r_v >= VS_BEGIN) && (r_v < VS_END);
   assign w_fs         = (r_h == '0) && (r_v == '0);
   assign w_word_start = w_vis && (r_h[3:0] == 4'd0);

   // Fetch is issued on the edge into the first column of each word so that the registered
   // read lands exactly when the serialiser needs to reload.
   assign w_fetch    = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT) && (w_h_nxt[3:0] == 4'd0);
   assign w_addr_nxt = ADDR_WIDTH'(SCREEN_BASE + 32'(w_v_nxt) * WPR + 32'(w_h_nxt >> 4));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_h     <= '0;
         r_v     <= '0;
         r_addr  <= ADDR_WIDTH'(SCREEN_BASE);
         r_shift <= '0;
         r_vis1  <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_fs1   <= 1'b0;
         r_load1 <= 1'b0;
         r_vis2  <= 1'b0;
         r_hs2   <= 1'b0;
         r_vs2   <= 1'b0;
         r_fs2   <= 1'b0;
      end else if (!enable) begin
         r_h     <= '0;
         r_v     <= '0;
         r_addr  <= ADDR_WIDTH'(SCREEN_BASE);
         r_shift <= '0;
         r_vis1  <= 1'b0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_fs1   <= 1'b0;
         r_load1 <= 1'b0;
         r_vis2  <= 1'b0;
         r_hs2   <= 1'b0;
         r_vs2   <= 1'b0;
         r_fs2   <= 1'b0;
      end else begin
         r_h <= w_h_nxt;
         r_v <= w_v_nxt;
         if (w_fetch) begin
            r_addr <= w_addr_nxt;
         end
         r_vis1  <= w_vis;
         r_hs1   <= w_hs;
         r_vs1   <= w_vs;
         r_fs1   <= w_fs;
         r_load1 <= w_word_start;
         r_vis2  <= r_vis1;
         r_hs2   <= r_hs1;
         r_vs2   <= r_vs1;
         r_fs2   <= r_fs1;
         r_shift <= r_load1 ? data_video : (r_shift >> 1);
      end
   end

   assign address_video = r_addr;
   assign pixel         = r_shift[0] & r_vis2;
   assign active        = r_vis2;
   assign hsync_n       = ~r_hs2;
   assign vsync_n       = ~r_vs2;
   assign frame_start   = r_fs2;

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner on a reduced raster; expected outputs come from the raster position
// implied by the number of consecutive enabled edges, looked up in a behavioural RAM image.
module tb_screen_scanner;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 16, VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int WPR = HA / 16;
   localparam int BASE = 16350;   // near the top so the screen wraps past address 0
   localparam int ASIZE = 16384;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [13:0] address_video;
   logic [15:0] data_video = '0;
   logic        pixel, active, hsync_n, vsync_n, frame_start;

   logic [15:0] ram [ASIZE];
   int          k = 0;        // consecutive enabled edges since last disable/reset
   int          checks = 0;
   int          failures = 0;

   screen_scanner #(
      .ADDR_WIDTH(14), .DATA_WIDTH(16), .SCREEN_BASE(BASE),
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .address_video(address_video), .data_video(data_video),
      .pixel(pixel), .active(active), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // Registered-read RAM video port.
   always @(posedge clock) data_video <= ram[address_video];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s t=%0t k=%0d observed=%0h expected=%0h", tag, $time, k, obs, expv);
      end
   endtask

   task automatic check_all();
      int pos, h, v, idx, p;
      logic e_pix, e_act, e_hsn, e_vsn, e_fs;
      // Address reflects the counters, which sit at raster position k.
      pos = k % FR;
      h = pos % HT;
      v = pos / HT;
      if (v >= VA)      idx = VA * WPR - 1;
      else if (h >= HA) idx = v * WPR + WPR - 1;
      else              idx = v * WPR + h / 16;
      chk("address_video", 32'(address_video), 32'((BASE + idx) % ASIZE));
      // Pixel outputs trail the counters by two edges.
      e_pix = 1'b0; e_act = 1'b0; e_hsn = 1'b1; e_vsn = 1'b1; e_fs = 1'b0;
      if (k >= 2) begin
         p = (k - 2) % FR;
         h = p % HT;
         v = p / HT;
         e_act = (h < HA) && (v < VA);
         if (e_act) e_pix = ram[(BASE + v * WPR + h / 16) % ASIZE][h % 16];
         e_hsn = !((h >= HA + HF) && (h < HA + HF + HS));
         e_vsn = !((v >= VA + VF) && (v < VA + VF + VS));
         e_fs  = (p == 0);
      end
      chk("pixel", 32'(pixel), 32'(e_pix));
      chk("active", 32'(active), 32'(e_act));
      chk("hsync_n", 32'(hsync_n), 32'(e_hsn));
      chk("vsync_n", 32'(vsync_n), 32'(e_vsn));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         if (enable) k++;
         else k = 0;
         @(negedge clock);
         check_all();
      end
   endtask

   initial begin
      for (int i = 0; i < ASIZE; i++) ram[i] = 16'($urandom);
      ram[BASE % ASIZE]         = 16'h0001;
      ram[(BASE + 1) % ASIZE]   = 16'h8000;
      ram[(BASE + WPR) % ASIZE] = 16'hFFFF;

      // Reset with enable high, then idle while disabled.
      reset  = 1'b1;
      enable = 1'b1;
      #3;
      k = 0;
      check_all();
      @(negedge clock);
      reset  = 1'b0;
      enable = 1'b0;
      step(5);

      // Full frame plus wrap into the next one.
      enable = 1'b1;
      step(FR + 200);

      // Drop enable mid-line in active video, re-enable 10 cycles later.
      while (k % FR != 3 * HT + 30) step(1);
      enable = 1'b0;
      step(10);
      enable = 1'b1;
      step(FR + 10);

      // Randomised enable pattern.
      for (int r = 0; r < 12; r++) begin
         enable = ($urandom_range(0, 4) != 0);
         step(int'($urandom_range(1, 400)));
      end
      enable = 1'b1;
      step(3 * HT + 40);

      // Asynchronous reset mid-line: outputs must go idle before any clock edge.
      #2;
      reset = 1'b1;
      #1;
      k = 0;
      check_all();
      @(negedge clock);
      reset = 1'b0;
      step(FR + 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/screen_scanner.md
# screen_scanner

- Video scan-out controller for the Hack screen buffer.
- Drives the RAM's read-only video port (`address_video` / `data_video`, one-cycle registered read) to sequence word fetches in raster order.
- Serialises each 16-bit word into pixels and generates horizontal/vertical sync, active-video and frame-start timing for the display interface.
- One pixel per `clock` cycle; never touches the CPU write port.

## Interface
- `ADDR_WIDTH`, 14: width of `address_video`; must match the RAM.
- `DATA_WIDTH`, 16: RAM word width; fixed at 16 (pixels per word).
- `SCREEN_BASE`, 0: RAM word address of screen pixel (0,0).
- `H_ACTIVE`, 512: visible pixels per line; multiple of 16.
- `H_FRONT`, 16 / `H_SYNC`, 64 / `H_BACK`, 48: horizontal porch and sync lengths, in pixels.
- `V_ACTIVE`, 256: visible lines.
- `V_FRONT`, 4 / `V_SYNC`, 2 / `V_BACK`, 18: vertical porch and sync lengths, in lines.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  scan-out run; low holds the raster at the origin.
- `address_video`  out  ADDR_WIDTH  registered word address to the RAM video port.
- `data_video`  in  DATA_WIDTH  RAM video read data; valid one cycle after `address_video` is sampled.
- `pixel`  out  1  current pixel bit (1 = black); 0 outside active video.
- `active`  out  1  high while `pixel` is a visible pixel.
- `hsync_n`  out  1  horizontal sync, active-low.
- `vsync_n`  out  1  vertical sync, active-low.
- `frame_start`  out  1  one-cycle pulse coincident with pixel (0,0) on the outputs.

## Operation
**Counters**
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 640).
- V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 280).
- `h` counts 0..H_TOTAL-1. At the wrap from H_TOTAL-1 to 0, `v` increments.
- `v` wraps from V_TOTAL-1 to 0.
- Both counters advance on every edge where `enable`=1.

**Decode for counter position (h,v)**
- Visible when h<H_ACTIVE and v<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
- vsync asserted for V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC, on every h of those lines.

**Addressing**
- WPR = H_ACTIVE/16 words per row (default 32).
- Word for (h,v) is SCREEN_BASE + v·WPR + h/16, truncated modulo 2^ADDR_WIDTH.
- `address_video` is loaded at the edge where the next counter value (h',v') is visible and h'[3:0]=0. It holds otherwise.
- Pixel column h maps to bit h mod 16 of its word: bit 0 is the leftmost pixel.

**Serialiser**
- A 16-bit shift register loads `data_video` at the start of each word.
- It shifts right one bit per cycle; `pixel` is its bit 0, gated by the delayed visible flag.

**Disable**
- While `enable`=0:
  - counters are held at (0,0);
  - `address_video` is held at SCREEN_BASE;
  - all delay stages are cleared, so outputs are idle (`pixel`=0, `active`=0, `hsync_n`=1, `vsync_n`=1, `frame_start`=0) from the first edge `enable` is sampled low.
- `enable` falling mid-frame aborts the frame.
- On re-enable, scanning starts at (0,0).

**Reset**
- Asynchronous. Forces counters to (0,0) and `address_video`=SCREEN_BASE.
- Outputs go to idle values (same as disable) immediately.
- Reset mid-frame behaves identically to disable followed by re-enable.

## Timing
- Reset values: `address_video`=SCREEN_BASE, `pixel`=0, `active`=0, `hsync_n`=1, `vsync_n`=1, `frame_start`=0.
- Fixed pipeline latency is 2 cycles. Outputs for position (h,v) appear exactly 2 cycles after the cycle in which the counters equal (h,v) with `enable`=1. Stages are:
  1. RAM read register;
  2. shift-register load.
- `hsync_n`, `vsync_n`, `active`, `frame_start` pass through the same 2-cycle delay and stay aligned with `pixel`.
- First pixel after enable: counters at (0,0) in the first enabled cycle C. `pixel`/`active`/`frame_start` for (0,0) appear in cycle C+2.
- `address_video` changes at most once per 16 cycles within a line. It is never updated during blanking, except for the prefetch of word 0 at the edge into h'=0 of a visible line.
- Frame period: H_TOTAL·V_TOTAL cycles (default 179200) between `frame_start` pulses.
- `active` high for exactly H_ACTIVE consecutive cycles per visible line.

## Test plan
1. Assert `reset` with `enable`=1, release; hold `enable`=0 for 5 cycles -> all outputs at idle values, `address_video`=0.
2. Preload word 0 = 16'h0001, word 1 = 16'h8000, word 32 = 16'hFFFF; raise `enable` -> on line 0, `pixel`=1 only at columns 0 and 31. On line 1, `pixel`=1 at columns 0..15. `frame_start` pulses 2 cycles after enable and lines up with column 0.
3. Line-start fetch sequence -> `address_video` steps 0,1,…,31 at 16-cycle intervals on line 0, then 32 at the edge into (0,1). The last visible word is 8191 (32·256−1).
4. Sync timing -> `active` high 512 cycles per line; `hsync_n` low 64 cycles starting 528 cycles after `active` rises; `vsync_n` low for lines 260–261 (1280 cycles); `frame_start` period 179200.
5. Drop `enable` at (300,100), re-raise 10 cycles later -> outputs idle from the next edge, `address_video`=0. The next `frame_start` comes 2 cycles after re-enable.
6. Assert `reset` asynchronously mid-line -> outputs idle without waiting for a clock edge. After release the raster restarts at (0,0), same as scenario 2.
